ball_ctrl: RTL and testbench



---
 rtl/breakout_pkg.sv | 15 +
 rtl/paddle_hit.sv | 39 +++
 rtl/ball_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ball_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared Breakout definitions: ball controller state encoding and keyboard codes.
package breakout_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MISS  = 2'd2,
    ST_OVER  = 2'd3
  } ball_state_t;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

endpackage

// File: rtl/paddle_hit.sv
// Combinational ball-versus-box collision test on the ball's next position.
// Only a descending ball can hit or miss; a hit always wins over the floor.
module paddle_hit #(
  parameter int SIZE  = 4,
  parameter int Y_MAX = 479
) (
  input  logic [9:0] i_next_x,
  input  logic [9:0] i_next_y,
  input  logic [9:0] i_dy,
  input  logic [9:0] i_bar_x,
  input  logic [9:0] i_bar_y,
  input  logic [9:0] i_bar_sizex,
  input  logic [9:0] i_bar_sizey,
  output logic       o_hit,
  output logic       o_miss
);

  logic        w_down;
  logic [10:0] w_dx_raw;
  logic [10:0] w_dx_abs;
  logic        w_top_ok;
  logic        w_bot_ok;
  logic        w_x_ok;
  logic        w_floor;

  assign w_down   = ~i_dy[9] & (i_dy != 10'd0);
  // Horizontal distance is taken in 11 bits so the sign survives the subtract.
  assign w_dx_raw = {1'b0, i_next_x} - {1'b0, i_bar_x};
  assign w_dx_abs = w_dx_raw[10] ? (~w_dx_raw + 11'd1) : w_dx_raw;
  // Paddle top edge test kept as a sum so a tall paddle near y=0 cannot underflow.
  assign w_top_ok = ({2'b00, i_next_y} + 12'(SIZE) + {2'b00, i_bar_sizey}) >= {2'b00, i_bar_y};
  assign w_bot_ok = i_next_y <= i_bar_y;
  assign w_x_ok   = w_dx_abs <= ({1'b0, i_bar_sizex} + 11'(SIZE));
  assign w_floor  = ({1'b0, i_next_y} + 11'(SIZE)) >= 11'(Y_MAX);

  assign o_hit  = w_down & w_top_ok & w_bot_ok & w_x_ok;
  assign o_miss = w_down & w_floor & ~o_hit;

endmodule

// File: rtl/ball_ctrl.sv
// Breakout ball motion and rally controller, updated once per frame.
//   state    | meaning
//   SERVE    | ball parked on paddle, waiting for space
//   PLAY     | ball moving, wall/paddle reflection, miss detection
//   MISS     | ball frozen, paddle held in reset for MISS_HOLD frames
//   OVER     | no lives left, waiting for space to restart
module ball_ctrl
  import breakout_pkg::*;
#(
  parameter int X_BEGIN   = 320,
  parameter int Y_BEGIN   = 453,
  parameter int X_MIN     = 10,
  parameter int X_MAX     = 639,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int STEP      = 1,
  parameter int SIZE      = 4,
  parameter int LIVES     = 3,
  parameter int MISS_HOLD = 60
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] BarX,
  input  logic [9:0] BarY,
  input  logic [9:0] Bar_Sizex,
  input  logic [9:0] Bar_Sizey,
  output logic [9:0] BallX,
  output logic [9:0] BallY,
  output logic [9:0] Ball_Size,
  output logic       Bar_Reset,
  output logic [1:0] Lives,
  output logic       Game_Over
);

  localparam int         CNT_W  = (MISS_HOLD > 2) ? $clog2(MISS_HOLD) : 1;
  localparam logic [9:0] STEP_P = 10'(STEP);
  localparam logic [9:0] STEP_N = 10'(-STEP);

  ball_state_t      r_state, w_state_nxt;
  logic [9:0]       r_ball_x, r_ball_y, r_dx, r_dy;
  logic [9:0]       w_ball_x_nxt, w_ball_y_nxt, w_dx_nxt, w_dy_nxt;
  logic [1:0]       r_lives, w_lives_nxt;
  logic             r_bar_reset, w_bar_reset_nxt;
  logic             r_game_over;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [9:0] w_next_x, w_next_y, w_park_y;
  logic       w_wall_l, w_wall_r, w_wall_t, w_space, w_hit, w_miss;

  assign w_next_x = r_ball_x + r_dx;
  assign w_next_y = r_ball_y + r_dy;
  assign w_park_y = BarY - Bar_Sizey - 10'(SIZE);
  assign w_space  = (keycode == KEY_SPACE);

  // Wall tests compare against sums on the non-negative side; the ball holds its
  // position on the reflecting axis for the frame the wall is seen.
  assign w_wall_l = r_dx[9] & ({1'b0, r_ball_x} <= 11'(X_MIN + SIZE + STEP));
  assign w_wall_r = ~r_dx[9] & (r_dx != 10'd0) &
                    (({1'b0, r_ball_x} + 11'(SIZE + STEP)) >= 11'(X_MAX));
  assign w_wall_t = r_dy[9] & ({1'b0, r_ball_y} <= 11'(Y_MIN + SIZE + STEP));

  paddle_hit #(.SIZE(SIZE), .Y_MAX(Y_MAX)) u_paddle_hit (
    .i_next_x   (w_next_x),
    .i_next_y   (w_next_y),
    .i_dy       (r_dy),
    .i_bar_x    (BarX),
    .i_bar_y    (BarY),
    .i_bar_sizex(Bar_Sizex),
    .i_bar_sizey(Bar_Sizey),
    .o_hit      (w_hit),
    .o_miss     (w_miss)
  );

  // Next-state, motion, position, lives and paddle-reset decisions for this frame.
  always_comb begin
    w_state_nxt     = r_state;
    w_ball_x_nxt    = r_ball_x;
    w_ball_y_nxt    = r_ball_y;
    w_dx_nxt        = r_dx;
    w_dy_nxt        = r_dy;
    w_lives_nxt     = r_lives;
    w_cnt_nxt       = r_cnt;
    w_bar_reset_nxt = 1'b0;
    case (r_state)
      ST_SERVE: begin
        w_ball_x_nxt = BarX;
        w_ball_y_nxt = w_park_y;
        if (w_space) begin
          w_state_nxt = ST_PLAY;
          w_dx_nxt    = STEP_P;
          w_dy_nxt    = STEP_N;
        end
      end
      ST_PLAY: begin
        if (w_wall_l)      w_dx_nxt     = STEP_P;
        else if (w_wall_r) w_dx_nxt     = STEP_N;
        else               w_ball_x_nxt = w_next_x;
        if (w_wall_t) begin
          w_dy_nxt = STEP_P;
        end else if (w_hit) begin
          w_dy_nxt     = STEP_N;
          w_ball_y_nxt = w_park_y;
        end else if (w_miss) begin
          w_lives_nxt     = r_lives - 2'd1;
          w_cnt_nxt       = '0;
          w_state_nxt     = ST_MISS;
          w_bar_reset_nxt = 1'b1;
        end else begin
          w_ball_y_nxt = w_next_y;
        end
      end
      ST_MISS: begin
        if (r_cnt == CNT_W'(MISS_HOLD - 1)) begin
          w_state_nxt = (r_lives != 2'd0) ? ST_SERVE : ST_OVER;
        end else begin
          w_cnt_nxt       = r_cnt + 1'b1;
          w_bar_reset_nxt = 1'b1;
        end
      end
      ST_OVER: begin
        if (w_space) begin
          w_lives_nxt     = 2'(LIVES);
          w_state_nxt     = ST_SERVE;
          w_bar_reset_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_SERVE;
    endcase
  end

  // Frame-rate register bank; every output changes on the same edge.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_SERVE;
      r_ball_x    <= 10'(X_BEGIN);
      r_ball_y    <= 10'(Y_BEGIN);
      r_dx        <= '0;
      r_dy        <= '0;
      r_lives     <= 2'(LIVES);
      r_bar_reset <= 1'b0;
      r_game_over <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ball_x    <= w_ball_x_nxt;
      r_ball_y    <= w_ball_y_nxt;
      r_dx        <= w_dx_nxt;
      r_dy        <= w_dy_nxt;
      r_lives     <= w_lives_nxt;
      r_bar_reset <= w_bar_reset_nxt;
      r_game_over <= (w_state_nxt == ST_OVER);
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign BallX     = r_ball_x;
  assign BallY     = r_ball_y;
  assign Ball_Size = 10'(SIZE);
  assign Bar_Reset = r_bar_reset;
  assign Lives     = r_lives;
  assign Game_Over = r_game_over;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: serve table, directed rally corner cases and a
// randomized run, all shadowed frame by frame by an integer game model.
module tb_ball_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic [9:0] BarX, BarY, Bar_Sizex, Bar_Sizey;
  logic [9:0] BallX, BallY, Ball_Size;
  logic       Bar_Reset, Game_Over;
  logic [1:0] Lives;

  int errors = 0;
  int checks = 0;

  localparam int MS = 0, MP = 1, MM = 2, MO = 3;
  int m_x, m_y, m_dx, m_dy, m_lives, m_hold, m_mode;
  bit m_br;

  typedef struct {
    logic [9:0] bar_x;
    logic [9:0] bar_y;
    logic [9:0] bar_sy;
    logic [7:0] key;
    logic [9:0] exp_x;
    logic [9:0] exp_y;
    logic [1:0] exp_lives;
  } vec_t;
  vec_t vecs[6];

  ball_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .BarX(BarX), .BarY(BarY), .Bar_Sizex(Bar_Sizex), .Bar_Sizey(Bar_Sizey),
    .BallX(BallX), .BallY(BallY), .Ball_Size(Ball_Size),
    .Bar_Reset(Bar_Reset), .Lives(Lives), .Game_Over(Game_Over)
  );

  always #5 frame_clk = ~frame_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 320; m_y = 453; m_dx = 0; m_dy = 0;
    m_lives = 3; m_hold = 0; m_mode = MS; m_br = 0;
  endtask

  // One frame of game rules in plain integer arithmetic.
  task automatic model_step(input int bx, input int by, input int bsx, input int bsy, input bit space);
    int nx, ny, adx;
    case (m_mode)
      MS: begin
        m_br = 0;
        m_x  = bx;
        m_y  = (by - bsy - 4) & 1023;
        if (space) begin m_mode = MP; m_dx = 1; m_dy = -1; end
      end
      MP: begin
        m_br = 0;
        nx = m_x + m_dx;
        ny = m_y + m_dy;
        if (m_dx < 0 && m_x <= 15)          m_dx = 1;
        else if (m_dx > 0 && m_x + 5 >= 639) m_dx = -1;
        else                                 m_x = nx & 1023;
        adx = nx - bx;
        if (adx < 0) adx = -adx;
        if (m_dy < 0 && m_y <= 5) begin
          m_dy = 1;
        end else if (m_dy > 0 && ny + 4 + bsy >= by && ny <= by && adx <= bsx + 4) begin
          m_dy = -1;
          m_y  = (by - bsy - 4) & 1023;
        end else if (m_dy > 0 && ny + 4 >= 479) begin
          m_lives--; m_hold = 0; m_mode = MM; m_br = 1;
        end else begin
          m_y = ny & 1023;
        end
      end
      MM: begin
        if (m_hold == 59) begin
          m_br = 0;
          m_mode = (m_lives != 0) ? MS : MO;
        end else begin
          m_hold++; m_br = 1;
        end
      end
      default: begin
        m_br = 0;
        if (space) begin m_lives = 3; m_mode = MS; m_br = 1; end
      end
    endcase
  endtask

  // Advance one frame in DUT and model together and compare every output.
  task automatic tick();
    logic [31:0] exp;
    model_step(int'(BarX), int'(BarY), int'(Bar_Sizex), int'(Bar_Sizey), keycode == 8'h2C);
    @(posedge frame_clk);
    #1;
    exp = {8'd0, m_x[9:0], m_y[9:0], m_lives[1:0], m_br, (m_mode == MO)};
    check("lockstep", {8'd0, BallX, BallY, Lives, Bar_Reset, Game_Over}, exp);
  endtask

  // Paddle X placed at a chosen offset from where the ball will be next frame.
  function automatic logic [9:0] track(input int off);
    int t;
    t = m_x + m_dx + off;
    if (t < 0) t = 0;
    if (t > 1023) t = 1023;
    return t[9:0];
  endfunction

  task automatic run_miss(input string name);
    bit seen;
    int n;
    seen = 0;
    for (int k = 0; k < 1500 && !seen; k++) begin
      BarX = track(-25);
      tick();
      if (Bar_Reset) seen = 1;
    end
    check({name, "_seen"}, seen, 1);
    n = 0;
    while (Bar_Reset && n < 100) begin n++; tick(); end
    check({name, "_hold"}, n, 60);
  endtask

  initial begin
    bit found;
    int sy;

    vecs[0] = '{10'd200, 10'd460, 10'd3, 8'h00, 10'd200, 10'd453, 2'd3};
    vecs[1] = '{10'd100, 10'd470, 10'd5, 8'h04, 10'd100, 10'd461, 2'd3};
    vecs[2] = '{10'd320, 10'd460, 10'd3, 8'h07, 10'd320, 10'd453, 2'd3};
    vecs[3] = '{10'd320, 10'd460, 10'd3, 8'h2C, 10'd320, 10'd453, 2'd3};
    vecs[4] = '{10'd320, 10'd460, 10'd3, 8'h00, 10'd321, 10'd452, 2'd3};
    vecs[5] = '{10'd320, 10'd460, 10'd3, 8'h2C, 10'd322, 10'd451, 2'd3};

    Reset = 1'b1;
    keycode = 8'h00;
    BarX = 10'd320; BarY = 10'd460; Bar_Sizex = 10'd20; Bar_Sizey = 10'd3;
    model_reset();
    #12;
    check("rst_ballx", BallX, 320);
    check("rst_bally", BallY, 453);
    check("rst_lives", Lives, 3);
    check("rst_bar_reset", Bar_Reset, 0);
    check("rst_game_over", Game_Over, 0);
    check("ball_size", Ball_Size, 4);
    Reset = 1'b0;

    // Serve table: paddle tracking, non-space keys ignored, launch latency.
    for (int i = 0; i < 6; i++) begin
      BarX = vecs[i].bar_x; BarY = vecs[i].bar_y; Bar_Sizey = vecs[i].bar_sy;
      keycode = vecs[i].key;
      tick();
      check($sformatf("vec%0d", i), {BallX, BallY, Lives},
            {vecs[i].exp_x, vecs[i].exp_y, vecs[i].exp_lives});
    end
    keycode = 8'h00;

    // Top wall: ball rests one frame at y=5, then descends.
    found = 0;
    for (int k = 0; k < 600 && !found; k++) begin
      tick();
      if (BallY == 10'd5) found = 1;
    end
    check("top_reach", found, 1);
    tick();
    check("top_hold", BallY, 5);
    tick();
    check("top_turn", BallY, 6);

    // Paddle edge at +24 from the ball: bounce.
    found = 0;
    for (int k = 0; k < 600 && !found; k++) begin
      BarX = track(24);
      tick();
      if (BallY == 10'd453) found = 1;
    end
    check("bounce_reach", found, 1);
    BarX = track(24);
    tick();
    check("bounce_up", BallY, 452);
    check("bounce_lives", Lives, 3);

    // Paddle at -25: miss, 60-frame Bar_Reset, back to serve.
    run_miss("miss1");
    check("miss1_lives", Lives, 2);
    BarX = 10'd250;
    tick();
    check("serve_track", {BallX, BallY}, {10'd250, 10'd453});

    keycode = 8'h2C; tick(); keycode = 8'h00;
    run_miss("miss2");
    check("miss2_lives", Lives, 1);
    BarX = 10'd250;
    keycode = 8'h2C; tick(); keycode = 8'h00;
    run_miss("miss3");
    check("over_lives", Lives, 0);
    check("over_flag", Game_Over, 1);
    tick();
    check("over_stays", {Lives, Game_Over}, {2'd0, 1'b1});
    keycode = 8'h2C; tick(); keycode = 8'h00;
    check("restart", {Lives, Bar_Reset, Game_Over}, {2'd3, 1'b1, 1'b0});
    tick();
    check("restart_pulse_end", Bar_Reset, 0);

    // Corner: left wall and paddle edge in the same frame.
    BarX = 10'd634; BarY = 10'd207; Bar_Sizey = 10'd3;
    tick();
    keycode = 8'h2C; tick(); keycode = 8'h00;
    BarX = 10'd900; BarY = 10'd1000;
    found = 0;
    for (int k = 0; k < 800 && !found; k++) begin
      tick();
      if (BallX == 10'd15) found = 1;
    end
    check("corner_reach", found, 1);
    check("corner_y", BallY, 429);
    BarX = 10'd38; BarY = 10'd437;
    tick();
    check("corner_hit", {BallX, BallY}, {10'd15, 10'd430});
    tick();
    check("corner_after", {BallX, BallY}, {10'd16, 10'd429});

    // Asynchronous reset in the middle of the miss hold.
    BarY = 10'd460;
    found = 0;
    for (int k = 0; k < 1500 && !found; k++) begin
      BarX = track(-25);
      tick();
      if (Bar_Reset) found = 1;
    end
    check("miss4_seen", found, 1);
    for (int k = 0; k < 30; k++) tick();
    #3;
    Reset = 1'b1;
    #1;
    model_reset();
    check("async_reset", {BallX, BallY, Lives, Bar_Reset, Game_Over},
          {10'd320, 10'd453, 2'd3, 1'b0, 1'b0});
    #2;
    Reset = 1'b0;

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      sy = int'($urandom_range(10, 2));
      Bar_Sizey = 10'(sy);
      Bar_Sizex = 10'($urandom_range(40, 4));
      BarY = 10'($urandom_range(470, sy + 14));
      if (m_mode == MP) BarX = track(int'($urandom_range(60, 0)) - 30);
      else              BarX = 10'($urandom_range(630, 16));
      keycode = ($urandom_range(5, 0) == 0) ? 8'h2C : 8'($urandom_range(255, 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
